// File: rtl/esm_pkg.sv
// Package shared by the dependency-matrix tracker and its helpers.
// Contents:
//   HAZ_RAW/HAZ_WAR/HAZ_WAW  bit positions inside the HAZ_EN hazard-enable mask
//   idx_w()                  index width for an N-entry space (minimum 1 bit),
//                            used to derive RW (register index) and IW (slot index)
package esm_pkg;

   localparam int HAZ_RAW = 0;
   localparam int HAZ_WAR = 1;
   localparam int HAZ_WAW = 2;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-index free-slot picker for the instruction window.
// Ports:
//   free_mask  in   BS  bit i set when slot i is free
//   free_idx   out  IW  lowest free slot (0 when no slot is free)
//   any_free   out  1   at least one slot is free
// Purely combinational.
module free_slot_finder
   import esm_pkg::*;
#(
   parameter int BS = 16,
   parameter int IW = idx_w(BS)
)(
   input  logic [BS-1:0] free_mask,
   output logic [IW-1:0] free_idx,
   output logic          any_free
);

   logic [IW-1:0] idx_s;
   logic          found_s;

   // Priority scan from slot 0 upward; the first free slot wins.
   always_comb begin
      idx_s   = '0;
      found_s = 1'b0;
      for (int i = 0; i < BS; i++) begin
         if (free_mask[i] && !found_s) begin
            idx_s   = IW'(i);
            found_s = 1'b1;
         end else begin
            idx_s   = idx_s;
            found_s = found_s;
         end
      end
   end

   assign free_idx = idx_s;
   assign any_free = found_s;

endmodule

// File: rtl/dep_matrix_tracker.sv
// Instruction-window dependency tracker.
// Holds BS in-flight instructions and a BS x BS dependency matrix
// (row = consumer, column = producer) and reports which entries may issue.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous clear of the whole window
//   alloc_valid/alloc_ready  allocation handshake (ready = any free slot)
//   alloc_rs1/rs2/rd         operand registers of the offered instruction
//   alloc_idx                slot the offered instruction would take
//   ret_valid/ret_idx        retire request (ignored for an empty slot)
//   entry_valid              occupied slots
//   issue_ready              occupied slots whose dependency row is empty
//   dep_rd_idx/dep_rd_row    combinational matrix row read (0 for empty slot)
//   occupancy                number of occupied slots
module dep_matrix_tracker
   import esm_pkg::*;
#(
   parameter int         REGNUM        = 32,
   parameter int         BS            = 16,
   parameter logic [2:0] HAZ_EN        = 3'b111,
   parameter bit         ZERO_REG_FREE = 1'b1,
   localparam int        RW            = idx_w(REGNUM),
   localparam int        IW            = idx_w(BS)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          alloc_valid,
   output logic          alloc_ready,
   input  logic [RW-1:0] alloc_rs1,
   input  logic [RW-1:0] alloc_rs2,
   input  logic [RW-1:0] alloc_rd,
   output logic [IW-1:0] alloc_idx,
   input  logic          ret_valid,
   input  logic [IW-1:0] ret_idx,
   output logic [BS-1:0] entry_valid,
   output logic [BS-1:0] issue_ready,
   input  logic [IW-1:0] dep_rd_idx,
   output logic [BS-1:0] dep_rd_row,
   output logic [IW:0]   occupancy
);

   logic [BS-1:0]          valid_r;
   logic [BS-1:0][BS-1:0]  mat_r;
   logic [RW-1:0]          rs1_r [BS];
   logic [RW-1:0]          rs2_r [BS];
   logic [RW-1:0]          rd_r  [BS];
   logic [IW:0]            occ_r;
   logic [BS-1:0]          issue_r;

   logic [IW-1:0]          free_idx_s;
   logic                   any_free_s;
   logic                   alloc_fire_s;
   logic                   ret_fire_s;
   logic [BS-1:0]          alloc_oh_s;
   logic [BS-1:0]          ret_oh_s;
   logic [BS-1:0]          raw_s;
   logic [BS-1:0]          war_s;
   logic [BS-1:0]          waw_s;
   logic [BS-1:0]          dep_vec_s;
   logic [BS-1:0]          valid_nxt_s;
   logic [BS-1:0][BS-1:0]  mat_nxt_s;
   logic [IW:0]            occ_nxt_s;
   logic [BS-1:0]          issue_nxt_s;
   logic [BS-1:0]          rd_row_s;

   // Register 0 can be declared dependency-free: equal values that are both 0 never match.
   function automatic logic reg_match(input logic [RW-1:0] a, input logic [RW-1:0] b);
      return (a == b) && !(ZERO_REG_FREE && (a == {RW{1'b0}}));
   endfunction

   free_slot_finder #(
      .BS (BS),
      .IW (IW)
   ) u_free_slot_finder (
      .free_mask (~valid_r),
      .free_idx  (free_idx_s),
      .any_free  (any_free_s)
   );

   assign alloc_fire_s = alloc_valid & any_free_s;
   assign ret_fire_s   = ret_valid & valid_r[ret_idx];
   assign alloc_oh_s   = {BS{alloc_fire_s}} & ({{(BS-1){1'b0}}, 1'b1} << free_idx_s);
   assign ret_oh_s     = {BS{ret_fire_s}} & ({{(BS-1){1'b0}}, 1'b1} << ret_idx);

   // Hazard compare of the offered instruction against every stored entry.
   // A producer retiring this very cycle is excluded so no stale bit survives.
   always_comb begin
      raw_s     = '0;
      war_s     = '0;
      waw_s     = '0;
      dep_vec_s = '0;
      for (int j = 0; j < BS; j++) begin
         raw_s[j] = reg_match(rd_r[j], alloc_rs1) | reg_match(rd_r[j], alloc_rs2);
         war_s[j] = reg_match(rs1_r[j], alloc_rd) | reg_match(rs2_r[j], alloc_rd);
         waw_s[j] = reg_match(rd_r[j], alloc_rd);
         if (valid_r[j] && !ret_oh_s[j] && (free_idx_s != IW'(j))) begin
            dep_vec_s[j] = (HAZ_EN[HAZ_RAW] & raw_s[j]) |
                           (HAZ_EN[HAZ_WAR] & war_s[j]) |
                           (HAZ_EN[HAZ_WAW] & waw_s[j]);
         end else begin
            dep_vec_s[j] = 1'b0;
         end
      end
   end

   // Next window state: flush wins, otherwise retire and allocate both apply.
   always_comb begin
      valid_nxt_s = valid_r;
      mat_nxt_s   = mat_r;
      issue_nxt_s = '0;
      if (flush) begin
         valid_nxt_s = '0;
         mat_nxt_s   = '0;
      end else begin
         valid_nxt_s = (valid_r & ~ret_oh_s) | alloc_oh_s;
         for (int i = 0; i < BS; i++) begin
            if (alloc_oh_s[i]) begin
               mat_nxt_s[i] = dep_vec_s;
            end else if (ret_oh_s[i]) begin
               mat_nxt_s[i] = '0;
            end else begin
               // Clear the retiring producer's column and the new slot's column.
               mat_nxt_s[i] = mat_r[i] & ~ret_oh_s & ~alloc_oh_s;
            end
         end
      end
      for (int i = 0; i < BS; i++) begin
         issue_nxt_s[i] = valid_nxt_s[i] & (mat_nxt_s[i] == {BS{1'b0}});
      end
   end

   // Occupancy update: net zero when an allocate and a retire coincide.
   always_comb begin
      occ_nxt_s = occ_r;
      if (flush) begin
         occ_nxt_s = '0;
      end else begin
         case ({alloc_fire_s, ret_fire_s})
            2'b10:   occ_nxt_s = occ_r + {{IW{1'b0}}, 1'b1};
            2'b01:   occ_nxt_s = occ_r - {{IW{1'b0}}, 1'b1};
            default: occ_nxt_s = occ_r;
         endcase
      end
   end

   // Window state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= '0;
         mat_r   <= '0;
         occ_r   <= '0;
         issue_r <= '0;
      end else begin
         valid_r <= valid_nxt_s;
         mat_r   <= mat_nxt_s;
         occ_r   <= occ_nxt_s;
         issue_r <= issue_nxt_s;
      end
   end

   // Stored operand registers, written on allocation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BS; i++) begin
            rs1_r[i] <= '0;
            rs2_r[i] <= '0;
            rd_r[i]  <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < BS; i++) begin
            rs1_r[i] <= '0;
            rs2_r[i] <= '0;
            rd_r[i]  <= '0;
         end
      end else if (alloc_fire_s) begin
         rs1_r[free_idx_s] <= alloc_rs1;
         rs2_r[free_idx_s] <= alloc_rs2;
         rd_r[free_idx_s]  <= alloc_rd;
      end
   end

   // Matrix row read port; empty slots read as zero.
   always_comb begin
      rd_row_s = '0;
      if (valid_r[dep_rd_idx]) begin
         rd_row_s = mat_r[dep_rd_idx];
      end else begin
         rd_row_s = '0;
      end
   end

   assign alloc_ready = any_free_s;
   assign alloc_idx   = free_idx_s;
   assign entry_valid = valid_r;
   assign issue_ready = issue_r;
   assign dep_rd_row  = rd_row_s;
   assign occupancy   = occ_r;

endmodule

// File: tb/tb_dep_matrix_tracker.sv
// Bench for dep_matrix_tracker with BS=4, REGNUM=32.
// Four instances share one stimulus stream:
//   g=0 defaults, g=1 ZERO_REG_FREE=0, g=2 HAZ_EN=3'b001, g=3 HAZ_EN=3'b010.
// Reference model: each slot remembers its allocation order; consumer c depends on
// producer p when both are occupied, p was allocated earlier, and an enabled hazard
// exists between their registers.
module tb_dep_matrix_tracker;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       alloc_valid;
   logic [4:0] alloc_rs1, alloc_rs2, alloc_rd;
   logic       ret_valid;
   logic [1:0] ret_idx;
   logic [1:0] dep_rd_idx;

   logic       ar_o  [4];
   logic [1:0] ai_o  [4];
   logic [3:0] ev_o  [4];
   logic [3:0] ir_o  [4];
   logic [3:0] row_o [4];
   logic [2:0] occ_o [4];

   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dep_matrix_tracker #(
         .REGNUM        (32),
         .BS            (4),
         .HAZ_EN        ((g == 2) ? 3'b001 : ((g == 3) ? 3'b010 : 3'b111)),
         .ZERO_REG_FREE ((g == 1) ? 1'b0 : 1'b1)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .flush       (flush),
         .alloc_valid (alloc_valid),
         .alloc_ready (ar_o[g]),
         .alloc_rs1   (alloc_rs1),
         .alloc_rs2   (alloc_rs2),
         .alloc_rd    (alloc_rd),
         .alloc_idx   (ai_o[g]),
         .ret_valid   (ret_valid),
         .ret_idx     (ret_idx),
         .entry_valid (ev_o[g]),
         .issue_ready (ir_o[g]),
         .dep_rd_idx  (dep_rd_idx),
         .dep_rd_row  (row_o[g]),
         .occupancy   (occ_o[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit         m_valid [4];
   logic [4:0] m_rs1   [4];
   logic [4:0] m_rs2   [4];
   logic [4:0] m_rd    [4];
   int         m_seq   [4];
   int         seq_ctr = 0;

   function automatic logic [2:0] haz_of(input int g);
      case (g)
         2:       return 3'b001;
         3:       return 3'b010;
         default: return 3'b111;
      endcase
   endfunction

   function automatic bit zrf_of(input int g);
      return (g == 1) ? 1'b0 : 1'b1;
   endfunction

   function automatic bit reg_eq(input logic [4:0] a, input logic [4:0] b, input bit z);
      return (a == b) && !(z && (a == 5'd0));
   endfunction

   function automatic bit depends(input int g, input int c, input int p);
      logic [2:0] h;
      bit z, raw, war, waw;
      h   = haz_of(g);
      z   = zrf_of(g);
      raw = reg_eq(m_rd[p], m_rs1[c], z) || reg_eq(m_rd[p], m_rs2[c], z);
      war = reg_eq(m_rs1[p], m_rd[c], z) || reg_eq(m_rs2[p], m_rd[c], z);
      waw = reg_eq(m_rd[p], m_rd[c], z);
      return (h[0] && raw) || (h[1] && war) || (h[2] && waw);
   endfunction

   function automatic logic [3:0] exp_row(input int g, input int c);
      logic [3:0] r;
      r = 4'b0000;
      if (m_valid[c]) begin
         for (int p = 0; p < 4; p++) begin
            if (m_valid[p] && (m_seq[p] < m_seq[c]) && depends(g, c, p)) r[p] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_seq[i]   = 0;
      end
   endtask

   // Applies the rules of one clock edge using the inputs present at that edge.
   task automatic model_update();
      int n;
      bit rf;
      if (flush) begin
         model_clear();
      end else begin
         rf = ret_valid && m_valid[ret_idx];
         n  = lowest_free();
         if (rf) m_valid[ret_idx] = 1'b0;
         if (alloc_valid && (n >= 0)) begin
            m_valid[n] = 1'b1;
            m_rs1[n]   = alloc_rs1;
            m_rs2[n]   = alloc_rs2;
            m_rd[n]    = alloc_rd;
            seq_ctr++;
            m_seq[n]   = seq_ctr;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, g, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [3:0] ev, ir;
      int occ, n;
      for (int g = 0; g < 4; g++) begin
         ev  = 4'b0000;
         ir  = 4'b0000;
         occ = 0;
         for (int i = 0; i < 4; i++) begin
            ev[i] = m_valid[i];
            ir[i] = m_valid[i] && (exp_row(g, i) == 4'b0000);
            if (m_valid[i]) occ++;
         end
         n = lowest_free();
         chk("entry_valid", g, 32'(ev_o[g]), 32'(ev));
         chk("issue_ready", g, 32'(ir_o[g]), 32'(ir));
         chk("occupancy", g, 32'(occ_o[g]), 32'(occ));
         chk("alloc_ready", g, 32'(ar_o[g]), 32'(n >= 0));
         if (n >= 0) chk("alloc_idx", g, 32'(ai_o[g]), 32'(n));
         chk("dep_rd_row", g, 32'(row_o[g]), 32'(exp_row(g, int'(dep_rd_idx))));
      end
   endtask

   // Drive inputs at posedge+1, compare at posedge+3.
   task automatic drive(input logic f, input logic a, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic r, input logic [1:0] ri, input logic [1:0] di);
      flush       = f;
      alloc_valid = a;
      alloc_rs1   = s1;
      alloc_rs2   = s2;
      alloc_rd    = d;
      ret_valid   = r;
      ret_idx     = ri;
      dep_rd_idx  = di;
      #2;
      check_all();
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_clear();
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- directed table (checked against instance 0) ----------------
   typedef struct {
      logic       f, a;
      logic [4:0] s1, s2, d;
      logic       r;
      logic [1:0] ri, di;
      logic [3:0] ev, ir;
      logic [2:0] occ;
      logic       ar;
      logic [1:0] ai;
      logic [3:0] row;
   } vec_t;

   vec_t tbl [15];

   initial begin
      // inputs of this cycle | outputs expected before this cycle's edge
      tbl[0]  = '{1'b0, 1'b1, 5'd1,  5'd2,  5'd3,  1'b0, 2'd0, 2'd0, 4'b0000, 4'b0000, 3'd0, 1'b1, 2'd0, 4'b0000};
      tbl[1]  = '{1'b0, 1'b1, 5'd3,  5'd4,  5'd5,  1'b0, 2'd0, 2'd0, 4'b0001, 4'b0001, 3'd1, 1'b1, 2'd1, 4'b0000};
      tbl[2]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 2'd1, 4'b0011, 4'b0001, 3'd2, 1'b1, 2'd2, 4'b0001};
      tbl[3]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 2'd0, 2'd1, 4'b0011, 4'b0001, 3'd2, 1'b1, 2'd2, 4'b0001};
      tbl[4]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 2'd3, 2'd1, 4'b0010, 4'b0010, 3'd1, 1'b1, 2'd0, 4'b0000};
      tbl[5]  = '{1'b0, 1'b1, 5'd10, 5'd11, 5'd12, 1'b0, 2'd0, 2'd1, 4'b0010, 4'b0010, 3'd1, 1'b1, 2'd0, 4'b0000};
      tbl[6]  = '{1'b0, 1'b1, 5'd13, 5'd14, 5'd15, 1'b0, 2'd0, 2'd0, 4'b0011, 4'b0011, 3'd2, 1'b1, 2'd2, 4'b0000};
      tbl[7]  = '{1'b0, 1'b1, 5'd16, 5'd17, 5'd18, 1'b0, 2'd0, 2'd2, 4'b0111, 4'b0111, 3'd3, 1'b1, 2'd3, 4'b0000};
      tbl[8]  = '{1'b0, 1'b1, 5'd20, 5'd21, 5'd22, 1'b0, 2'd0, 2'd3, 4'b1111, 4'b1111, 3'd4, 1'b0, 2'd0, 4'b0000};
      tbl[9]  = '{1'b0, 1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 2'd2, 2'd3, 4'b1111, 4'b1111, 3'd4, 1'b0, 2'd0, 4'b0000};
      tbl[10] = '{1'b0, 1'b1, 5'd20, 5'd21, 5'd22, 1'b0, 2'd0, 2'd2, 4'b1011, 4'b1011, 3'd3, 1'b1, 2'd2, 4'b0000};
      tbl[11] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 2'd1, 2'd2, 4'b1111, 4'b1111, 3'd4, 1'b0, 2'd0, 4'b0000};
      tbl[12] = '{1'b0, 1'b1, 5'd12, 5'd0,  5'd30, 1'b1, 2'd0, 2'd0, 4'b1101, 4'b1101, 3'd3, 1'b1, 2'd1, 4'b0000};
      tbl[13] = '{1'b1, 1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 2'd2, 2'd1, 4'b1110, 4'b1110, 3'd3, 1'b1, 2'd0, 4'b0000};
      tbl[14] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 2'd0, 4'b0000, 4'b0000, 3'd0, 1'b1, 2'd0, 4'b0000};

      rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_rs1 = 5'd0; alloc_rs2 = 5'd0;
      alloc_rd = 5'd0; ret_valid = 1'b0; ret_idx = 2'd0; dep_rd_idx = 2'd0;
      model_clear();
      #2;
      chk("reset_entry_valid", 0, 32'(ev_o[0]), 32'h0);
      chk("reset_occupancy", 0, 32'(occ_o[0]), 32'h0);
      chk("reset_alloc_ready", 0, 32'(ar_o[0]), 32'h1);
      chk("reset_alloc_idx", 0, 32'(ai_o[0]), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 0; k < 15; k++) begin
         drive(tbl[k].f, tbl[k].a, tbl[k].s1, tbl[k].s2, tbl[k].d, tbl[k].r, tbl[k].ri, tbl[k].di);
         chk($sformatf("tbl%0d_entry_valid", k), 0, 32'(ev_o[0]), 32'(tbl[k].ev));
         chk($sformatf("tbl%0d_issue_ready", k), 0, 32'(ir_o[0]), 32'(tbl[k].ir));
         chk($sformatf("tbl%0d_occupancy", k), 0, 32'(occ_o[0]), 32'(tbl[k].occ));
         chk($sformatf("tbl%0d_alloc_ready", k), 0, 32'(ar_o[0]), 32'(tbl[k].ar));
         if (tbl[k].ar) chk($sformatf("tbl%0d_alloc_idx", k), 0, 32'(ai_o[0]), 32'(tbl[k].ai));
         chk($sformatf("tbl%0d_dep_rd_row", k), 0, 32'(row_o[0]), 32'(tbl[k].row));
         finish_cycle();
      end

      // Zero register: I0 rd=0, I1 all-zero registers.
      drive(1'b0, 1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 2'd0, 2'd0); finish_cycle();
      drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0); finish_cycle();
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd1);
      chk("zero_row1", 0, 32'(row_o[0]), 32'h0);
      chk("zero_row1", 1, 32'(row_o[1]), 32'h1);
      finish_cycle();
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0); finish_cycle();

      // Hazard enables: I0 (rs1=7, rs2=9, rd=8), I1 (rs1=1, rs2=2, rd=7) is WAR only.
      drive(1'b0, 1'b1, 5'd7, 5'd9, 5'd8, 1'b0, 2'd0, 2'd0); finish_cycle();
      drive(1'b0, 1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 2'd0, 2'd0); finish_cycle();
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd1);
      chk("haz_row1", 0, 32'(row_o[0]), 32'h1);
      chk("haz_row1", 2, 32'(row_o[2]), 32'h0);
      chk("haz_row1", 3, 32'(row_o[3]), 32'h1);
      chk("haz_issue", 2, 32'(ir_o[2]), 32'h3);
      finish_cycle();

      // Randomized traffic with a mid-run asynchronous reset.
      for (int k = 0; k < 400; k++) begin
         if (k == 200) do_reset();
         drive(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 9) < 6),
               5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
               ($urandom_range(0, 9) < 4),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         finish_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dep_matrix_tracker.md
Name: dep_matrix_tracker

Overview:
- Parametrised successor to the per-instruction dependency table in the ESM front end.
- Holds a window of BS in-flight instructions with a handshake allocator and a BS×BS dependency matrix (row = consumer, column = producer).
- Supports selectable hazard classes, an optional hard-wired zero register, retirement-driven column clearing and flush.
- Feeds the issue stage with a per-entry ready vector.

Parameters:
- REGNUM, 32, architectural register count; register index width RW = $clog2(REGNUM).
- BS, 16, window depth (power of two, ≥2); index width IW = $clog2(BS).
- HAZ_EN, 3'b111, hazard enables: bit0 RAW, bit1 WAR, bit2 WAW.
- ZERO_REG_FREE, 1, when 1, register 0 never creates or carries a dependency.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of the whole window.
- alloc_valid  in  1  new instruction offered.
- alloc_ready  out  1  window has a free slot.
- alloc_rs1, alloc_rs2, alloc_rd  in  RW each  operand registers of the offered instruction.
- alloc_idx  out  IW  slot the offered instruction will take (lowest free index).
- ret_valid  in  1  retire request.
- ret_idx  in  IW  slot being retired.
- entry_valid  out  BS  occupied slots.
- issue_ready  out  BS  bit i = entry_valid[i] & (row i == 0).
- dep_rd_idx  in  IW  matrix read address.
- dep_rd_row  out  BS  combinational read of row dep_rd_idx (zero if that slot is invalid).
- occupancy  out  IW+1  number of valid entries.

Behaviour:
- Reset (async, rst=1): all valid bits, matrix bits and stored registers cleared. Outputs: entry_valid=0, issue_ready=0, occupancy=0, alloc_ready=1, alloc_idx=0, dep_rd_row=0.
- alloc_ready = ~&entry_valid. It is combinational from state only; a retire in the same cycle does not raise it.
- Allocation fires when alloc_valid & alloc_ready at posedge. Slot n = alloc_idx gets:
  - valid set;
  - rs1/rs2/rd stored;
  - row n written with dependency vector D; column n cleared in all rows.
- D[j], for each valid j ≠ n, is the OR of the enabled hazards:
  - RAW: rd_j == rs1 or rd_j == rs2.
  - WAR: rs1_j == rd or rs2_j == rd.
  - WAW: rd_j == rd.
- With ZERO_REG_FREE=1, any comparison whose register value is 0 is false.
- D uses pre-edge state. If retire fires the same cycle for slot j, D[j] is forced 0.
- Retire fires when ret_valid & entry_valid[ret_idx]. At the edge it clears valid[ret_idx], row ret_idx, and column ret_idx in every row. A retire of an invalid slot is ignored.
- Simultaneous alloc and retire: both take effect. Alloc cannot target the retiring slot because that slot was valid pre-edge.
- Latency:
  - a new entry appears in entry_valid/issue_ready one cycle after the allocation edge;
  - a producer's retire clears consumer rows at the same edge, so issue_ready rises the next cycle.
- flush: at posedge, same effect as reset and takes priority over alloc/retire that cycle.
- occupancy is a registered count: +1 on alloc, −1 on retire, both on simultaneous events gives net 0.
- No self-dependency: the diagonal is always 0.
- Reset asserted mid-operation discards all state immediately; no partial updates.

Decomposition:
- Package esm_pkg:
  - hazard-enable bit positions (HAZ_RAW=0, HAZ_WAR=1, HAZ_WAW=2);
  - localparam helpers for RW/IW.
- One sub-module, free_slot_finder: parametrised on BS, takes ~entry_valid, returns the lowest free index and an any-free flag. It is purely combinational.
- Matrix, compare logic and counters stay in the top module.

Test Plan (BS=4, REGNUM=32, defaults unless stated):
- Reset, then alloc I0 (rs1=1, rs2=2, rd=3), then I1 (rs1=3, rs2=4, rd=5) → I0 in slot0, I1 in slot1; row1=4'b0001 (RAW); issue_ready=4'b0001; occupancy=2.
- Retire slot0 with I1 present → next cycle row1=0, issue_ready=4'b0010, occupancy=1. Retiring invalid slot 3 → no state change.
- Fill all 4 slots → alloc_ready=0; alloc_valid held high is not accepted. Retire slot2 and offer alloc in the same cycle → alloc not taken that cycle; next cycle alloc_idx=2 and the alloc is accepted.
- ZERO_REG_FREE: I0 rd=0, I1 rs1=0 rs2=0 rd=0 → row1=0. With ZERO_REG_FREE=0 → row1=4'b0001.
- HAZ_EN=3'b001: I0 (rs1=7, rd=8), I1 (rd=7) → WAR masked, row1=0. With HAZ_EN=3'b010 → row1=4'b0001.
- Simultaneous retire slot0 and alloc I2 reading slot0's rd → I2 row bit0=0. A flush the same cycle wins: entry_valid=0, occupancy=0.
